// File: rtl/kp_stream_pkg.sv
// Shared types for the keypoint/descriptor stream between the streamer and the matcher.
package kp_stream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } kp_state_e;

    localparam logic [15:0] DONE_CODE = 16'h0001;
    localparam int          ENTRY_W   = 96;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] d3;
        logic [15:0] d4;
    } kp_entry_t;

    function automatic logic [31:0] pack_keypoint(input logic [15:0] x, input logic [15:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/kp_buffer.sv
// Simple dual-port keypoint entry RAM: one write port, one registered read port.
module kp_buffer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 96
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; data holds while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/keypoint_streamer.sv
// Buffers one frame of keypoints plus descriptors, then replays them to the matcher
// as valid/ready beats followed by a single done word.
module keypoint_streamer
    import kp_stream_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          AW        = 8,
    parameter logic [15:0] DONE_CODE = kp_stream_pkg::DONE_CODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kp_in_valid,
    output logic        kp_in_ready,
    input  logic [15:0] kp_in_x,
    input  logic [15:0] kp_in_y,
    input  logic [15:0] desc_in_1,
    input  logic [15:0] desc_in_2,
    input  logic [15:0] desc_in_3,
    input  logic [15:0] desc_in_4,
    input  logic        frame_end,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_keypoint,
    output logic [15:0] out_desc_1,
    output logic [15:0] out_desc_2,
    output logic [15:0] out_desc_3,
    output logic [15:0] out_desc_4,
    output logic [15:0] out_done,
    output logic [AW:0] out_count,
    output logic        overflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    kp_state_e     state_r, state_nxt_s;
    logic [AW:0]   count_r, count_nxt_s, rd_ptr_r;
    logic          overflow_r, overflow_nxt_s;
    logic          wr_en_s, rd_en_s;
    logic [AW-1:0] wr_addr_s;
    logic          q_valid_r, out_valid_r, kp_in_ready_r;
    logic          out_load_s, q_adv_s, drain_end_s;
    logic [15:0]   out_done_r;
    logic [ENTRY_W-1:0] wr_data_s, rd_data_s;
    kp_entry_t     wr_entry_s, rd_entry_s, out_entry_r;

    assign wr_entry_s = '{y: kp_in_y, x: kp_in_x, d1: desc_in_1, d2: desc_in_2,
                          d3: desc_in_3, d4: desc_in_4};
    assign wr_data_s  = wr_entry_s;
    assign rd_entry_s = kp_entry_t'(rd_data_s);

    kp_buffer #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // Two-stage read pipeline: RAM read register (q) feeding the output register.
    // The output stage loads whenever it is empty or its beat is being taken.
    assign out_load_s  = !out_valid_r || out_ready;
    assign q_adv_s     = !q_valid_r || out_load_s;
    assign rd_en_s     = (state_r == DRAIN) && q_adv_s && (rd_ptr_r < count_r);
    assign drain_end_s = (state_r == DRAIN) && (rd_ptr_r == count_r) && !q_valid_r && out_load_s;

    // Next-state, write-side and count/overflow decode
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        overflow_nxt_s = overflow_r;
        wr_en_s        = 1'b0;
        wr_addr_s      = count_r[AW-1:0];
        case (state_r)
            IDLE: begin
                wr_addr_s = {AW{1'b0}};
                if (kp_in_valid || frame_end) begin
                    wr_en_s        = kp_in_valid;
                    count_nxt_s    = kp_in_valid ? ONE_C : {(AW+1){1'b0}};
                    overflow_nxt_s = 1'b0;
                    state_nxt_s    = frame_end ? DRAIN : COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (kp_in_valid && (count_r < DEPTH_C)) begin
                    wr_en_s     = 1'b1;
                    count_nxt_s = count_r + ONE_C;
                end else if (kp_in_valid) begin
                    overflow_nxt_s = 1'b1;
                end else begin
                    count_nxt_s = count_r;
                end
                state_nxt_s = frame_end ? DRAIN : COLLECT;
            end
            DRAIN: begin
                state_nxt_s = drain_end_s ? DONE : DRAIN;
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, pointers and RAM read-stage valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            rd_ptr_r   <= {(AW+1){1'b0}};
            q_valid_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            overflow_r <= overflow_nxt_s;
            if (state_r == DONE) begin
                rd_ptr_r <= {(AW+1){1'b0}};
            end else if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            if (state_r != DRAIN) begin
                q_valid_r <= 1'b0;
            end else if (q_adv_s) begin
                q_valid_r <= rd_en_s;
            end
        end
    end

    // Registered matcher-facing outputs and input-side ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_entry_r   <= '0;
            out_done_r    <= 16'h0000;
            kp_in_ready_r <= 1'b1;
        end else begin
            if (out_load_s) begin
                out_valid_r <= q_valid_r;
                if (q_valid_r) begin
                    out_entry_r <= rd_entry_s;
                end
            end
            out_done_r    <= (state_nxt_s == DONE) ? DONE_CODE : 16'h0000;
            kp_in_ready_r <= (state_nxt_s == IDLE) ||
                             ((state_nxt_s == COLLECT) && (count_nxt_s < DEPTH_C));
        end
    end

    assign kp_in_ready  = kp_in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_keypoint = pack_keypoint(out_entry_r.x, out_entry_r.y);
    assign out_desc_1   = out_entry_r.d1;
    assign out_desc_2   = out_entry_r.d2;
    assign out_desc_3   = out_entry_r.d3;
    assign out_desc_4   = out_entry_r.d4;
    assign out_done     = out_done_r;
    assign out_count    = count_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_keypoint_streamer.sv
// Self-checking bench: two streamer instances (deep and 4-entry) share stimulus; a queue model predicts beats.
module tb_keypoint_streamer;

    localparam int BD = 256;
    localparam int BAW = 8;
    localparam int SD = 4;
    localparam int SAW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic kp_in_valid = 1'b0;
    logic frame_end = 1'b0;
    logic out_ready = 1'b1;
    logic [15:0] kp_in_x = 16'h0, kp_in_y = 16'h0;
    logic [15:0] desc_in_1 = 16'h0, desc_in_2 = 16'h0, desc_in_3 = 16'h0, desc_in_4 = 16'h0;

    logic b_ready, b_valid, b_ovf;
    logic [31:0] b_kp;
    logic [15:0] b_d1, b_d2, b_d3, b_d4, b_done;
    logic [BAW:0] b_count;
    logic s_ready, s_valid, s_ovf;
    logic [31:0] s_kp;
    logic [15:0] s_d1, s_d2, s_d3, s_d4, s_done;
    logic [SAW:0] s_count;

    always #5 clk = ~clk;

    keypoint_streamer #(.DEPTH(BD), .AW(BAW), .DONE_CODE(16'h0001)) u_big (
        .clk(clk), .rst_n(rst_n), .kp_in_valid(kp_in_valid), .kp_in_ready(b_ready),
        .kp_in_x(kp_in_x), .kp_in_y(kp_in_y), .desc_in_1(desc_in_1), .desc_in_2(desc_in_2),
        .desc_in_3(desc_in_3), .desc_in_4(desc_in_4), .frame_end(frame_end), .out_ready(out_ready),
        .out_valid(b_valid), .out_keypoint(b_kp), .out_desc_1(b_d1), .out_desc_2(b_d2),
        .out_desc_3(b_d3), .out_desc_4(b_d4), .out_done(b_done), .out_count(b_count), .overflow(b_ovf));

    keypoint_streamer #(.DEPTH(SD), .AW(SAW), .DONE_CODE(16'h0001)) u_small (
        .clk(clk), .rst_n(rst_n), .kp_in_valid(kp_in_valid), .kp_in_ready(s_ready),
        .kp_in_x(kp_in_x), .kp_in_y(kp_in_y), .desc_in_1(desc_in_1), .desc_in_2(desc_in_2),
        .desc_in_3(desc_in_3), .desc_in_4(desc_in_4), .frame_end(frame_end), .out_ready(out_ready),
        .out_valid(s_valid), .out_keypoint(s_kp), .out_desc_1(s_d1), .out_desc_2(s_d2),
        .out_desc_3(s_d3), .out_desc_4(s_d4), .out_done(s_done), .out_count(s_count), .overflow(s_ovf));

    bit sel = 1'b0;
    logic m_valid, m_ready, m_ovf;
    logic [31:0] m_kp;
    logic [63:0] m_desc;
    logic [15:0] m_done;
    logic [8:0] m_count;

    always_comb begin
        if (sel) begin
            m_valid = s_valid; m_ready = s_ready; m_ovf = s_ovf; m_kp = s_kp;
            m_desc = {s_d1, s_d2, s_d3, s_d4}; m_done = s_done; m_count = {6'd0, s_count};
        end else begin
            m_valid = b_valid; m_ready = b_ready; m_ovf = b_ovf; m_kp = b_kp;
            m_desc = {b_d1, b_d2, b_d3, b_d4}; m_done = b_done; m_count = b_count;
        end
    end

    int total = 0;
    int bad = 0;

    // reference model: every accepted keypoint in arrival order, {y, x, d1..d4}
    logic [95:0] exp_q[$];
    bit exp_ovf;
    int model_depth;

    logic [95:0] got_q[$];
    int first_cyc, done_cyc, done_seen, last_xfer, stall_changes;
    logic [15:0] done_val;

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        model_depth = sel ? SD : BD;
    endtask

    task automatic drive_cycle(input bit v, input bit fe, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
                               input logic [15:0] d4, output bit rdy);
        @(negedge clk);
        rdy = m_ready;
        kp_in_valid = v; frame_end = fe;
        kp_in_x = x; kp_in_y = y;
        desc_in_1 = d1; desc_in_2 = d2; desc_in_3 = d3; desc_in_4 = d4;
        if (v) begin
            if (exp_q.size() < model_depth) exp_q.push_back({y, x, d1, d2, d3, d4});
            else exp_ovf = 1'b1;
        end
    endtask

    // Records beats/done timing; cycle c is observed after the c-th edge past frame_end
    task automatic capture(input int max_cyc, input int mode);
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit prev_stall = 1'b0;
        logic [95:0] prev_beat = 96'h0;
        int vcnt = 0;
        got_q.delete();
        first_cyc = -1; done_cyc = -1; done_seen = 0; last_xfer = -1; stall_changes = 0;
        done_val = 16'h0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            kp_in_valid = 1'b0; frame_end = 1'b0;
            if (prev_stall && (!m_valid || {m_kp, m_desc} !== prev_beat)) stall_changes++;
            if (m_done !== 16'h0) begin
                done_seen++;
                if (done_cyc < 0) begin done_cyc = cyc; done_val = m_done; end
            end
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = (vcnt < 7) ? pat[vcnt] : 1'b1;
                    default: out_ready = ($urandom_range(3) != 0);
                endcase
                vcnt++;
                if (out_ready) begin got_q.push_back({m_kp, m_desc}); last_xfer = cyc; end
                prev_stall = !out_ready;
                prev_beat = {m_kp, m_desc};
            end else begin
                prev_stall = 1'b0;
                out_ready = 1'b1;
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
        end
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (b_valid !== 1'b0 || b_kp !== 32'h0 || {b_d1, b_d2, b_d3, b_d4} !== 64'h0 || b_done !== 16'h0
            || b_count !== 9'h0 || b_ovf !== 1'b0 || b_ready !== 1'b1) begin
            bad++; $display("FAIL reset_big: valid=%b kp=%h done=%h count=%0d ovf=%b ready=%b, required 0/0/0/0/0/1",
                            b_valid, b_kp, b_done, b_count, b_ovf, b_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_valid !== 1'b0 || s_kp !== 32'h0 || {s_d1, s_d2, s_d3, s_d4} !== 64'h0 || s_done !== 16'h0
            || s_count !== 3'h0 || s_ovf !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL reset_small: valid=%b kp=%h done=%h count=%0d ovf=%b ready=%b, required 0/0/0/0/0/1",
                            s_valid, s_kp, s_done, s_count, s_ovf, s_ready);
        end
    endtask

    task automatic test_basic();
        bit r;
        sel = 1'b0; model_reset();
        drive_cycle(1'b1, 1'b0, 16'd5, 16'd7, 16'd1, 16'd2, 16'd3, 16'd4, r);
        drive_cycle(1'b1, 1'b0, 16'd10, 16'd20, 16'd5, 16'd6, 16'd7, 16'd8, r);
        drive_cycle(1'b1, 1'b0, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, r);
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        capture(40, 0);
        total++; if (first_cyc !== 2) begin bad++; $display("FAIL basic_first: got %0d required 2", first_cyc); end
        total++; if (got_q.size() !== 3) begin bad++; $display("FAIL basic_beats: got %0d required 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 3) begin
            total++;
            if ({got_q[0][95:64], got_q[1][95:64], got_q[2][95:64]} !== {32'h00070005, 32'h0014000A, 32'h0000FFFF}) begin
                bad++; $display("FAIL basic_kp: got %h %h %h", got_q[0][95:64], got_q[1][95:64], got_q[2][95:64]);
            end
        end
        total++; if (done_cyc !== 5 || done_val !== 16'h0001 || done_seen !== 1) begin
            bad++; $display("FAIL basic_done: cyc=%0d val=%h n=%0d required 5/0001/1", done_cyc, done_val, done_seen); end
        total++; if (m_count !== 9'd3 || m_ovf !== 1'b0) begin
            bad++; $display("FAIL basic_count: count=%0d ovf=%b required 3/0", m_count, m_ovf); end
    endtask

    task automatic test_empty();
        bit r;
        sel = 1'b0; model_reset();
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        capture(20, 0);
        total++; if (got_q.size() !== 0 || first_cyc !== -1) begin
            bad++; $display("FAIL empty_beats: got %0d beats required 0", got_q.size()); end
        total++; if (done_cyc !== 1 || done_val !== 16'h0001 || done_seen !== 1) begin
            bad++; $display("FAIL empty_done: cyc=%0d val=%h n=%0d required 1/0001/1", done_cyc, done_val, done_seen); end
        total++; if (m_count !== 9'd0) begin bad++; $display("FAIL empty_count: got %0d required 0", m_count); end
    endtask

    task automatic test_overflow();
        bit r;
        sel = 1'b1; model_reset();
        for (int i = 1; i <= 6; i++) begin
            drive_cycle(1'b1, 1'b0, 16'(i), 16'(i + 100), 16'($urandom()), 16'($urandom()),
                        16'($urandom()), 16'($urandom()), r);
            total++;
            if (r !== ((i - 1) < SD)) begin bad++; $display("FAIL ovf_ready%0d: got %b required %b", i, r, ((i - 1) < SD)); end
        end
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        capture(40, 0);
        total++; if (m_ovf !== 1'b1 || m_count !== 9'd4) begin
            bad++; $display("FAIL ovf_flag: ovf=%b count=%0d required 1/4", m_ovf, m_count); end
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL ovf_beats: got %0d required 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i][79:64] !== 16'(i + 1) || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done_cyc !== 6 || done_seen !== 1) begin
            bad++; $display("FAIL ovf_done: cyc=%0d n=%0d required 6/1", done_cyc, done_seen); end
    endtask

    task automatic test_backpressure();
        bit r;
        sel = 1'b0; model_reset();
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 1'b0, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
                        16'($urandom()), 16'($urandom()), r);
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        capture(40, 1);
        total++; if (stall_changes !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes required 0", stall_changes); end
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL bp_beats: got %0d required 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (done_cyc !== 9 || done_cyc !== last_xfer + 1 || done_seen !== 1) begin
            bad++; $display("FAIL bp_done: cyc=%0d last=%0d n=%0d required 9/8/1", done_cyc, last_xfer, done_seen); end
    endtask

    task automatic test_simultaneous();
        bit r;
        sel = 1'b0; model_reset();
        drive_cycle(1'b1, 1'b0, 16'd3, 16'd4, 16'd11, 16'd12, 16'd13, 16'd14, r);
        drive_cycle(1'b1, 1'b0, 16'd6, 16'd8, 16'd21, 16'd22, 16'd23, 16'd24, r);
        drive_cycle(1'b1, 1'b1, 16'd9, 16'd1, 16'd31, 16'd32, 16'd33, 16'd34, r);
        capture(40, 0);
        total++; if (got_q.size() !== 3) begin bad++; $display("FAIL simul_beats: got %0d required 3", got_q.size()); end
        if (got_q.size() == 3) begin
            total++;
            if (got_q[2][79:64] !== 16'd9 || got_q[2] !== exp_q[2]) begin
                bad++; $display("FAIL simul_last: got %h required %h", got_q[2], exp_q[2]); end
        end
        total++; if (m_count !== 9'd3 || done_cyc !== 5) begin
            bad++; $display("FAIL simul_count: count=%0d done=%0d required 3/5", m_count, done_cyc); end
    endtask

    task automatic test_reset_mid_drain();
        bit r;
        int nvalid = 0;
        int ndone = 0;
        sel = 1'b0; model_reset();
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b1, 1'b0, 16'(i + 1), 16'(i + 50), 16'($urandom()), 16'($urandom()),
                        16'($urandom()), 16'($urandom()), r);
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            kp_in_valid = 1'b0; frame_end = 1'b0;
            if (b_valid) nvalid++;
            if (b_done !== 16'h0) ndone++;
        end
        total++; if (nvalid !== 2) begin bad++; $display("FAIL rmd_pre: got %0d beats required 2", nvalid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (b_valid !== 1'b0 || b_kp !== 32'h0 || {b_d1, b_d2, b_d3, b_d4} !== 64'h0 || b_done !== 16'h0
            || b_count !== 9'h0 || b_ovf !== 1'b0 || b_ready !== 1'b1) begin
            bad++; $display("FAIL rmd_async: valid=%b kp=%h count=%0d ready=%b required 0/0/0/1", b_valid, b_kp, b_count, b_ready);
        end
        repeat (3) begin @(negedge clk); if (b_done !== 16'h0) ndone++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (b_done !== 16'h0) ndone++; end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rmd_nodone: got %0d done cycles required 0", ndone); end
        model_reset();
        drive_cycle(1'b1, 1'b0, 16'h1234, 16'h5678, 16'hA, 16'hB, 16'hC, 16'hD, r);
        drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
        capture(30, 0);
        total++;
        if (got_q.size() !== 1 || got_q[0] !== {16'h5678, 16'h1234, 16'hA, 16'hB, 16'hC, 16'hD}) begin
            bad++; $display("FAIL rmd_after: got %0d beats first %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 96'h0); end
        total++; if (done_cyc !== 3 || m_count !== 9'd1) begin
            bad++; $display("FAIL rmd_done: cyc=%0d count=%0d required 3/1", done_cyc, m_count); end
    endtask

    task automatic test_random();
        bit r;
        int n;
        bit fe_last;
        for (int f = 0; f < 8; f++) begin
            sel = f[0]; model_reset();
            n = $urandom_range(sel ? 7 : 12);
            fe_last = (n > 0) && ($urandom_range(1) == 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3) == 0)
                    drive_cycle(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
                drive_cycle(1'b1, fe_last && (i == n - 1), 16'($urandom()), 16'($urandom()), 16'($urandom()),
                            16'($urandom()), 16'($urandom()), 16'($urandom()), r);
            end
            if (!fe_last) drive_cycle(1'b0, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, r);
            capture(300, 2);
            total++; if (got_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL rnd%0d_beats: got %0d required %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_beat%0d: got %h required %h", f, i, got_q[i], exp_q[i]); end
            end
            total++; if (m_count !== 9'(exp_q.size()) || m_ovf !== exp_ovf) begin
                bad++; $display("FAIL rnd%0d_count: count=%0d ovf=%b required %0d/%b", f, m_count, m_ovf, exp_q.size(), exp_ovf); end
            total++;
            if (done_seen !== 1 || done_val !== 16'h0001 || stall_changes !== 0 ||
                done_cyc !== ((exp_q.size() == 0) ? 1 : last_xfer + 1) ||
                (exp_q.size() != 0 && first_cyc !== 2)) begin
                bad++; $display("FAIL rnd%0d_timing: done=%0d last=%0d first=%0d n=%0d stalls=%0d",
                                f, done_cyc, last_xfer, first_cyc, done_seen, stall_changes);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
